// File: rtl/rf_sec_pkg.sv
// Shared widths, constants and state encoding for the
// user-ID-tagged register file read path.
package rf_sec_pkg;
  localparam int ADDR_W = 4;
  localparam int UID_W  = 12;
  localparam int DATA_W = 16;

  localparam logic [UID_W-1:0]  UID_UNOWNED = 12'h000;
  localparam logic [ADDR_W-1:0] ADDR_LAST   = '1;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    RESP,
    LOCK
  } state_t;
endpackage

// File: rtl/rf_lockout_ctr.sv
// Consecutive-denial counter and lockout timer for the
// register file read port.
module rf_lockout_ctr #(
  parameter int MAX_DENY    = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic deny,
  input  logic grant,
  input  logic handshake,
  output logic trip,
  output logic locked_done
);
  logic [3:0] cnt;
  logic [7:0] tmr;

  assign trip        = handshake && deny
                     && (cnt == 4'(MAX_DENY - 1));
  assign locked_done = (tmr == 8'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      tmr <= '0;
    end else begin
      if (locked_done)
        cnt <= '0;
      else if (handshake && deny)
        cnt <= cnt + 4'd1;
      else if (handshake && grant)
        cnt <= '0;

      if (trip)
        tmr <= 8'(LOCK_CYCLES);
      else if (tmr != 8'd0)
        tmr <= tmr - 8'd1;
    end
  end
endmodule

// File: rtl/rf_read_ctrl.sv
// Owner-checked read controller: single reads or a full
// 16-register dump, with lockout after repeated denials.
module rf_read_ctrl
  import rf_sec_pkg::*;
#(
  parameter int MAX_DENY    = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [UID_W-1:0]  req_uid,
  input  logic              dump_start,
  output logic [ADDR_W-1:0] rf_adr,
  input  logic [DATA_W-1:0] rf_rs,
  input  logic [UID_W-1:0]  rf_uid_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_denied,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_last,
  output logic              dump_busy,
  output logic              locked
);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [UID_W-1:0]  uid_q;
  logic              grant_rd;
  logic              hs;
  logic              trip;
  logic              locked_done;

  assign grant_rd = (rf_uid_out == uid_q)
                 || (rf_uid_out == UID_UNOWNED);
  assign hs       = (state_q == RESP) && rsp_ready;

  rf_lockout_ctr #(
    .MAX_DENY    (MAX_DENY),
    .LOCK_CYCLES (LOCK_CYCLES)
  ) u_lockout (
    .clk         (clk),
    .rst_n       (rst_n),
    .deny        (rsp_denied),
    .grant       (!rsp_denied),
    .handshake   (hs),
    .trip        (trip),
    .locked_done (locked_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    locked    = 1'b0;
    rf_adr    = '0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid || dump_start)
          state_d = READ;
      end
      READ: begin
        rf_adr  = addr_q;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          if (trip)
            state_d = LOCK;
          else if (dump_busy && addr_q != ADDR_LAST)
            state_d = READ;
          else
            state_d = IDLE;
        end
      end
      LOCK: begin
        locked = 1'b1;
        if (locked_done)
          state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      uid_q      <= '0;
      dump_busy  <= 1'b0;
      rsp_data   <= '0;
      rsp_denied <= 1'b0;
      rsp_addr   <= '0;
      rsp_last   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q <= req_addr;
            uid_q  <= req_uid;
          end else if (dump_start) begin
            addr_q    <= '0;
            uid_q     <= req_uid;
            dump_busy <= 1'b1;
          end
        end
        READ: begin
          rsp_data   <= grant_rd ? rf_rs : '0;
          rsp_denied <= !grant_rd;
          rsp_addr   <= addr_q;
          rsp_last   <= dump_busy && (addr_q == ADDR_LAST);
        end
        RESP: begin
          if (rsp_ready) begin
            if (trip)
              dump_busy <= 1'b0;
            else if (dump_busy && addr_q != ADDR_LAST)
              addr_q <= addr_q + ADDR_W'(1);
            else
              dump_busy <= 1'b0;
          end
        end
        LOCK: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rf_read_ctrl.sv
// Directed plus randomized bench for rf_read_ctrl with a
// register-file model and an access-rule reference model.
module tb_rf_read_ctrl;
  localparam int MAX_DENY    = 3;
  localparam int LOCK_CYCLES = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_addr;
  logic [11:0] req_uid;
  logic        dump_start;
  logic [3:0]  rf_adr;
  logic [15:0] rf_rs;
  logic [11:0] rf_uid_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_denied;
  logic [3:0]  rsp_addr;
  logic        rsp_last;
  logic        dump_busy;
  logic        locked;

  logic [15:0] mem_data  [16];
  logic [11:0] mem_owner [16];

  int total = 0;
  int bad   = 0;
  int streak = 0;
  bit skip_lock = 0;

  assign rf_rs      = mem_data[rf_adr];
  assign rf_uid_out = mem_owner[rf_adr];

  always #5 clk = ~clk;

  rf_read_ctrl #(
    .MAX_DENY    (MAX_DENY),
    .LOCK_CYCLES (LOCK_CYCLES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_uid    (req_uid),
    .dump_start (dump_start),
    .rf_adr     (rf_adr),
    .rf_rs      (rf_rs),
    .rf_uid_out (rf_uid_out),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_denied (rsp_denied),
    .rsp_addr   (rsp_addr),
    .rsp_last   (rsp_last),
    .dump_busy  (dump_busy),
    .locked     (locked)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_grant(input logic [3:0] a,
                                     input logic [11:0] uid);
    return (mem_owner[a] == uid) || (mem_owner[a] == 12'h000);
  endfunction

  function automatic logic [11:0] pick_uid;
    int k;
    k = $urandom_range(0, 3);
    case (k)
      0:       return 12'h000;
      2:       return 12'h0B0;
      default: return 12'h0A5;
    endcase
  endfunction

  task automatic lock_check;
    int n;
    n = 0;
    while (locked === 1'b1 && n < 300) begin
      chk("lock_req_ready", {31'd0, req_ready}, 0);
      dump_start = (n == 2);
      n++;
      step;
      dump_start = 1'b0;
    end
    chk("lock_len", n, LOCK_CYCLES);
    chk("post_lock_ready", {31'd0, req_ready}, 1);
    chk("post_lock_dump", {31'd0, dump_busy}, 0);
    streak = 0;
  endtask

  task automatic after_rsp(input logic denied);
    if (denied) streak++;
    else        streak = 0;
    if (streak == MAX_DENY) begin
      chk("locked_rise", {31'd0, locked}, 1);
      if (skip_lock) streak = 0;
      else           lock_check();
    end else begin
      chk("not_locked", {31'd0, locked}, 0);
      chk("idle_state", {27'd0, req_ready, rf_adr}, {27'd0, 1'b1, 4'd0});
    end
  endtask

  task automatic do_read(input logic [3:0] a, input logic [11:0] uid,
                         input int stall);
    logic        g;
    logic [15:0] ed;
    logic [31:0] ev;
    g  = exp_grant(a, uid);
    ed = g ? mem_data[a] : 16'h0;
    ev = {9'd0, 1'b1, !g, 1'b0, a, ed};
    chk("req_ready", {31'd0, req_ready}, 1);
    req_valid = 1'b1;
    req_addr  = a;
    req_uid   = uid;
    rsp_ready = (stall == 0);
    step;
    req_valid  = 1'b0;
    dump_start = 1'b0;
    req_addr   = 4'($urandom);
    req_uid    = 12'($urandom);
    chk("read_rf_adr", {28'd0, rf_adr}, {28'd0, a});
    chk("early_valid", {31'd0, rsp_valid}, 0);
    step;
    chk("rsp", {9'd0, rsp_valid, rsp_denied, rsp_last, rsp_addr, rsp_data}, ev);
    chk("rsp_busy", {31'd0, dump_busy}, 0);
    for (int i = 0; i < stall; i++) begin
      step;
      chk("stall_hold",
          {9'd0, rsp_valid, rsp_denied, rsp_last, rsp_addr, rsp_data}, ev);
    end
    rsp_ready = 1'b1;
    step;
    chk("rsp_drop", {31'd0, rsp_valid}, 0);
    after_rsp(!g);
  endtask

  task automatic do_dump(input logic [11:0] uid);
    logic        g;
    logic [15:0] ed;
    logic [3:0]  av;
    int          w;
    chk("dump_ready", {31'd0, req_ready}, 1);
    rsp_ready  = 1'b1;
    dump_start = 1'b1;
    req_uid    = uid;
    step;
    dump_start = 1'b0;
    req_uid    = 12'($urandom);
    for (int a = 0; a < 16; a++) begin
      av = a[3:0];
      w  = 0;
      while (rsp_valid !== 1'b1 && w < 6) begin
        step;
        w++;
      end
      chk("dump_gap", w, 1);
      g  = exp_grant(av, uid);
      ed = g ? mem_data[av] : 16'h0;
      chk("dump_rsp",
          {9'd0, rsp_valid, rsp_denied, rsp_last, rsp_addr, rsp_data},
          {9'd0, 1'b1, !g, (a == 15), av, ed});
      chk("dump_busy", {31'd0, dump_busy}, 1);
      step;
      if (!g) streak++;
      else    streak = 0;
      if (streak == MAX_DENY) begin
        chk("dump_abort_lock", {31'd0, locked}, 1);
        chk("dump_abort_busy", {31'd0, dump_busy}, 0);
        lock_check();
        return;
      end
    end
    chk("dump_end_busy", {31'd0, dump_busy}, 0);
    chk("dump_end_idle", {30'd0, req_ready, rsp_valid}, {30'd0, 2'b10});
  endtask

  task automatic mid_reset;
    rst_n = 1'b0;
    #1;
    chk("rst_outs",
        {23'd0, rsp_valid, rsp_denied, rsp_last, dump_busy, locked,
         rsp_addr},
        32'd0);
    chk("rst_data", {12'd0, rf_adr, rsp_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step;
    chk("rst_release_ready", {31'd0, req_ready}, 1);
    streak = 0;
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_uid    = '0;
    dump_start = 1'b0;
    rsp_ready  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mem_data[i]  = 16'($urandom);
      mem_owner[i] = 12'h0A5;
    end
    mem_data[3]  = 16'h1234;
    mem_owner[7] = 12'h000;
    #3;
    chk("reset_outs",
        {23'd0, rsp_valid, rsp_denied, rsp_last, dump_busy, locked,
         rsp_addr},
        32'd0);
    chk("reset_data", {16'd0, rsp_data}, 32'd0);
    #9;
    rst_n = 1'b1;
    step;
    chk("reset_ready", {31'd0, req_ready}, 1);

    do_read(4'd3, 12'h0A5, 0);
    do_read(4'd3, 12'h0B0, 0);
    do_read(4'd7, 12'h0B0, 0);

    do_read(4'd3, 12'h0B0, 0);
    do_read(4'd3, 12'h0B0, 0);
    do_read(4'd3, 12'h0B0, 0);

    do_read(4'd3, 12'h0A5, 0);
    do_read(4'd3, 12'h0B0, 0);
    do_read(4'd3, 12'h0B0, 0);
    do_read(4'd7, 12'h0B0, 0);

    mem_owner[7] = 12'h0A5;
    do_dump(12'h0A5);

    do_read(4'd5, 12'h0A5, 10);

    dump_start = 1'b1;
    do_read(4'd7, 12'h0A5, 0);
    for (int i = 0; i < 4; i++) begin
      step;
      chk("no_extra_rsp", {30'd0, rsp_valid, dump_busy}, 0);
    end

    for (int n = 0; n < 30; n++) begin
      mem_owner[$urandom_range(0, 15)] = pick_uid();
      mem_data[$urandom_range(0, 15)]  = 16'($urandom);
      do_read(4'($urandom), pick_uid(), $urandom_range(0, 3));
    end

    for (int i = 0; i < 16; i++)
      mem_owner[i] = ($urandom_range(0, 5) == 0) ? 12'h0B0 : 12'h0A5;
    do_dump(12'h0A5);

    mem_owner[3] = 12'h0A5;
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 4'd3;
    req_uid   = 12'h0A5;
    step;
    req_valid = 1'b0;
    step;
    chk("pre_reset_resp", {31'd0, rsp_valid}, 1);
    mid_reset();

    skip_lock = 1;
    do_read(4'd3, 12'h0A5, 0);
    do_read(4'd3, 12'h0B0, 0);
    do_read(4'd3, 12'h0B0, 0);
    do_read(4'd3, 12'h0B0, 0);
    step;
    step;
    chk("pre_reset_lock", {31'd0, locked}, 1);
    mid_reset();
    skip_lock = 0;
    chk("post_reset_unlocked", {31'd0, locked}, 0);
    do_read(4'd3, 12'h0A5, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
